// File: rtl/score_bcd_counter.sv
// Score/combo accumulator for drum-hit judgements: serial 4-digit BCD score
// adder (one digit per cycle) with a saturating 2-digit BCD combo counter.
module score_bcd_counter #(
  parameter logic [3:0] GREAT_PTS = 4'd3,
  parameter logic [3:0] GOOD_PTS  = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hit_great,
  input  logic       hit_good,
  input  logic       miss,
  output logic [3:0] score_d0,
  output logic [3:0] score_d1,
  output logic [3:0] score_d2,
  output logic [3:0] score_d3,
  output logic [3:0] combo_d0,
  output logic [3:0] combo_d1,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t     state;
  logic [3:0] score [4];
  logic [3:0] work  [4];
  logic [3:0] combo [2];
  logic [3:0] amount;
  logic [1:0] idx;
  logic       carry;

  logic [3:0] addend;
  logic [4:0] sum;
  logic [3:0] digit_next;
  logic       carry_next;
  logic       hit;

  assign hit = hit_great | hit_good;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    addend     = (idx == 2'd0) ? amount : 4'd0;
    sum        = {1'b0, work[idx]} + {1'b0, addend} + {4'd0, carry};
    digit_next = sum[3:0];
    carry_next = 1'b0;
    if (sum > 5'd9) begin
      digit_next = sum[3:0] - 4'd10;
      carry_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the small digit arrays are flops, not RAM, so they are reset like any register.
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      carry    <= 1'b0;
      idx      <= 2'd0;
      amount   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        score[i] <= 4'd0;
        work[i]  <= 4'd0;
      end
      combo[0] <= 4'd0;
      combo[1] <= 4'd0;
    end else begin
      // Miss clears combo in any state; a hit only counts when idle and not missed.
      if (miss) begin
        combo[0] <= 4'd0;
        combo[1] <= 4'd0;
      end else if (state == IDLE && hit) begin
        if (combo[0] == 4'd9) begin
          if (combo[1] != 4'd9) begin
            combo[0] <= 4'd0;
            combo[1] <= combo[1] + 4'd1;
          end
        end else begin
          combo[0] <= combo[0] + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          if (!miss && hit) begin
            amount <= hit_great ? GREAT_PTS : GOOD_PTS;
            for (int i = 0; i < 4; i++) work[i] <= score[i];
            carry  <= 1'b0;
            idx    <= 2'd0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          work[idx] <= digit_next;
          carry     <= carry_next;
          if (idx == 2'd3) state <= COMMIT;
          else             idx   <= idx + 2'd1;
        end
        COMMIT: begin
          // A carry out of the thousands digit means the score saturates.
          if (carry) begin
            for (int i = 0; i < 4; i++) score[i] <= 4'd9;
            overflow <= 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) score[i] <= work[i];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign score_d0 = score[0];
  assign score_d1 = score[1];
  assign score_d2 = score[2];
  assign score_d3 = score[3];
  assign combo_d0 = combo[0];
  assign combo_d1 = combo[1];

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter: a decimal reference model pushes
// expected scores into a queue at each accepted hit; they are popped at commit.
module tb_score_bcd_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       hit_great, hit_good, miss;
  logic [3:0] score_d0, score_d1, score_d2, score_d3;
  logic [3:0] combo_d0, combo_d1;
  logic       busy, overflow;

  score_bcd_counter dut (
    .clk(clk), .reset(reset),
    .hit_great(hit_great), .hit_good(hit_good), .miss(miss),
    .score_d0(score_d0), .score_d1(score_d1),
    .score_d2(score_d2), .score_d3(score_d3),
    .combo_d0(combo_d0), .combo_d1(combo_d1),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int score;
    bit ovf;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_score = 0;
  int  m_combo = 0;
  bit  m_ovf   = 1'b0;

  function automatic logic [15:0] to_bcd(int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [15:0] score_obs();
    score_obs = {score_d3, score_d2, score_d1, score_d0};
  endfunction

  // Drive strobes from one negedge to the next, so exactly one rising edge samples them.
  task automatic strobe(bit g, bit gd, bit m);
    hit_great = g; hit_good = gd; miss = m;
    @(negedge clk);
    hit_great = 1'b0; hit_good = 1'b0; miss = 1'b0;
  endtask

  task automatic accept(string tag, bit g, bit gd);
    sb_t e;
    strobe(g, gd, 1'b0);
    m_combo = (m_combo < 99) ? m_combo + 1 : 99;
    m_score = m_score + (g ? 3 : 1);
    if (m_score > 9999) begin
      m_score = 9999;
      m_ovf   = 1'b1;
    end
    e.score = m_score;
    e.ovf   = m_ovf;
    sbq.push_back(e);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_combo"}, 32'({combo_d1, combo_d0}), 32'(to_bcd(m_combo)));
  endtask

  // Wait (bounded) for busy to fall, then compare the committed score against the queue.
  task automatic finish_add(string tag, int seen);
    int  cycles = seen;
    sb_t e;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      if (busy) cycles++;
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'd5);
    check({tag, "_qsize"}, 32'(sbq.size()), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_score"}, 32'(score_obs()), 32'(to_bcd(e.score)));
      check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic hit_and_wait(string tag, bit g, bit gd);
    accept(tag, g, gd);
    finish_add(tag, 1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_score"}, 32'(score_obs()), 32'h0);
    check({tag, "_combo"}, 32'({combo_d1, combo_d0}), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic model_reset();
    m_score = 0; m_combo = 0; m_ovf = 1'b0;
    sbq.delete();
  endtask

  initial begin
    hit_great = 1'b0; hit_good = 1'b0; miss = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Single good hit: 5 busy cycles, score 0001, combo 01.
    hit_and_wait("first_good", 1'b0, 1'b1);

    // Build to 0098, then great ripples a carry through d0 and d1 -> 0101.
    for (int i = 0; i < 32; i++) hit_and_wait("build98_great", 1'b1, 1'b0);
    hit_and_wait("build98_good", 1'b0, 1'b1);
    check("at_0098", 32'(score_obs()), 32'h0098);
    hit_and_wait("carry_ripple", 1'b1, 1'b0);
    check("at_0101", 32'(score_obs()), 32'h0101);

    // Build to 9998 with greats; combo saturates at 99 on the way.
    for (int i = 0; i < 3299; i++) hit_and_wait("build9998", 1'b1, 1'b0);
    check("at_9998", 32'(score_obs()), 32'h9998);
    check("combo_at_99", 32'({combo_d1, combo_d0}), 32'h99);
    hit_and_wait("saturate", 1'b1, 1'b0);
    check("sat_9999", 32'(score_obs()), 32'h9999);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("combo_stays_99", 32'({combo_d1, combo_d0}), 32'h99);

    strobe(1'b0, 1'b0, 1'b1);
    m_combo = 0;
    check("miss_idle_combo", 32'({combo_d1, combo_d0}), 32'h0);
    hit_and_wait("post_sat_good", 1'b0, 1'b1);
    check("post_sat_combo", 32'({combo_d1, combo_d0}), 32'h01);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all_zero("reset2");

    // Miss beats a simultaneous great; then great+good adds GREAT_PTS.
    hit_and_wait("pre_tie", 1'b0, 1'b1);
    strobe(1'b1, 1'b0, 1'b1);
    m_combo = 0;
    check("tie_miss_combo", 32'({combo_d1, combo_d0}), 32'h0);
    check("tie_miss_busy", 32'(busy), 32'd0);
    check("tie_miss_score", 32'(score_obs()), 32'h0001);
    @(negedge clk);
    check("tie_miss_busy_later", 32'(busy), 32'd0);
    hit_and_wait("great_and_good", 1'b1, 1'b1);
    check("great_wins", 32'(score_obs()), 32'h0004);

    // Hit strobed 2 cycles after an accepted hit is ignored.
    accept("ignore", 1'b0, 1'b1);
    @(negedge clk);
    strobe(1'b0, 1'b1, 1'b0);
    check("ignore_busy_held", 32'(busy), 32'd1);
    check("ignore_combo", 32'({combo_d1, combo_d0}), 32'(to_bcd(m_combo)));
    finish_add("ignore", 3);
    check("ignore_score", 32'(score_obs()), 32'h0005);

    // Miss mid-addition clears combo at once and leaves the sum intact.
    accept("miss_busy", 1'b1, 1'b0);
    @(negedge clk);
    strobe(1'b0, 1'b0, 1'b1);
    m_combo = 0;
    check("miss_busy_combo", 32'({combo_d1, combo_d0}), 32'h0);
    check("miss_busy_still_busy", 32'(busy), 32'd1);
    finish_add("miss_busy", 3);
    check("miss_busy_score", 32'(score_obs()), 32'h0008);
    check("miss_busy_combo_end", 32'({combo_d1, combo_d0}), 32'h0);

    // Reset at edge N+2 abandons the addition.
    accept("reset_mid", 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_all_zero("reset_mid");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_idle");
    hit_and_wait("after_reset", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
